load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Data-memory access stage directly downstream of the multicycle control FSM.
- Acts on the FSM's MEMREAD/MEMWRITE states: takes the ALU-computed address, funct3 and rs2 data.
- Performs a ready/request handshake with data memory, generates byte enables and lane-replicated write data, and returns the sign/zero-extended load result to the MEMWB result mux.
- Asserts busy so the FSM can hold its state while memory is slow.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles ACCESS waits for mem_ready before aborting with err.
- TIMEOUT_W, 5: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- read_en  input  1  start-load pulse (FSM MEMREAD).
- write_en  input  1  start-store pulse (FSM MemWrite).
- addr  input  32  byte address (ALU result).
- funct3  input  3  access size/sign from instruction.
- store_data  input  32  rs2 value.
- mem_req  output  1  memory request, held until accepted.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  output  32  word-aligned address {addr[31:2],2'b00}.
- mem_be  output  4  byte enables (bit i = byte lane i).
- mem_wdata  output  32  lane-replicated write data.
- mem_ready  input  1  memory accepts/completes the access this cycle.
- mem_rdata  input  32  read word, valid when mem_ready and !mem_we.
- load_data  output  32  extended load result, registered.
- busy  output  1  access in progress; FSM stalls.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle error pulse (misaligned, illegal funct3, conflict, timeout).

Behaviour:
- Reset (async, immediate): state IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, load_data=0, busy=0, done=0, err=0, timeout counter=0. Reset during ACCESS drops mem_req in the same cycle.
- States: IDLE, ACCESS, DONE.
- IDLE, start edge: read_en or write_en sampled high. Latch addr, funct3, store_data and the direction.
- IDLE, checks at the start edge. Any failure pulses err next cycle, issues no access and stays IDLE:
  - read_en && write_en is a conflict error.
  - Illegal funct3 for a load: 011, 110, 111.
  - Illegal funct3 for a store: any value >= 011.
  - Misaligned halfword: addr[0]=1.
  - Misaligned word: addr[1:0] != 00.
- IDLE, valid start: enter ACCESS. mem_req, busy, mem_we, mem_addr, mem_be and mem_wdata are registered and appear the cycle after the start edge.
- ACCESS: mem_req and all mem_* outputs stay stable until a cycle where mem_ready=1.
  - On that edge: capture the extended load result into load_data (loads only), deassert mem_req, enter DONE.
  - Latency with mem_ready already high: start edge, then 1 ACCESS cycle, then done.
- ACCESS timeout: the counter increments each ACCESS cycle without mem_ready. If it reaches TIMEOUT_CYCLES, drop mem_req, pulse err, go to IDLE. load_data is unchanged.
- DONE: done=1 and busy=0 for one cycle, then IDLE. A start in DONE is ignored; a start in ACCESS is ignored.
- Store lanes:
  - SB (000): mem_be=1<<addr[1:0]; mem_wdata={4{store_data[7:0]}}.
  - SH (001): mem_be=0011 if addr[1]=0, else 1100; mem_wdata={2{store_data[15:0]}}.
  - SW (010): mem_be=1111; mem_wdata=store_data.
- Loads: mem_be=1111. Byte lane is selected by addr[1:0], half lane by addr[1].
  - LB (000): sign-extend byte.
  - LH (001): sign-extend half.
  - LW (010): full word.
  - LBU (100): zero-extend byte.
  - LHU (101): zero-extend half.
- Stores leave load_data unchanged. load_data holds its value until the next successful load.

Test Plan:
- Reset mid-ACCESS: assert reset while mem_req=1 -> mem_req=0 and busy=0 immediately; load_data=0; the next start behaves normally.
- SB of store_data=0x000000A5, addr=0x1003, mem_ready high -> mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x1000, mem_we=1; done pulses 2 cycles after the start edge.
- LB vs LBU, mem_rdata=0x80FF7F01, addr=0x2002 -> LB gives load_data=0xFFFFFFFF; LBU gives 0x000000FF. With addr=0x2003, LB gives 0xFFFFFF80.
- LH, addr=0x3002, mem_rdata=0x8001_1234, mem_ready delayed 3 cycles -> mem_req held 4 cycles with stable outputs; busy=1 throughout; then load_data=0xFFFF8001 and done pulses.
- Errors, each with no mem_req and err pulsed one cycle:
  - LW at addr=0x4001.
  - SH at addr=0x4003.
  - Load with funct3=011.
  - read_en and write_en both high.
- Timeout: SW issued with mem_ready held 0 -> after 16 ACCESS cycles mem_req drops, err pulses, done never asserts, load_data unchanged.

Source files
------------

// File: rtl/load_store_unit.sv
// Data-memory access stage: turns FSM MEMREAD/MEMWRITE pulses into a held
// request/ready handshake with byte enables, lane-replicated stores and extended loads.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMEOUT_W      = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_en,
  input  logic        write_en,
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  localparam logic [TIMEOUT_W-1:0] TimeoutLast = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [TIMEOUT_W-1:0] timeoutCnt_q, timeoutCnt_d;
  logic               err_q, err_d;
  logic               we_q;
  logic [31:0]        addr_q;
  logic [3:0]         be_q, be_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [2:0]         f3_q;
  logic [1:0]         off_q;
  logic [31:0]        loadData_q, loadData_d;
  logic [31:0]        loadExt;
  logic [7:0]         byteSel;
  logic [15:0]        halfSel;
  logic               start, conflict, badF3, misaligned, startOk;

  assign start      = read_en | write_en;
  assign conflict   = read_en & write_en;
  assign badF3      = write_en ? (funct3 >= 3'd3)
                               : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
  assign misaligned = (funct3[1:0] == 2'b01 && addr[0]) ||
                      (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
  assign startOk    = start && !conflict && !badF3 && !misaligned;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      timeoutCnt_q <= '0;
      err_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      f3_q         <= '0;
      off_q        <= '0;
      loadData_q   <= '0;
    end else begin
      state_q      <= state_d;
      timeoutCnt_q <= timeoutCnt_d;
      err_q        <= err_d;
      loadData_q   <= loadData_d;
      if (state_q == IDLE && startOk) begin
        we_q    <= write_en;
        addr_q  <= {addr[31:2], 2'b00};
        be_q    <= be_d;
        wdata_q <= wdata_d;
        f3_q    <= funct3;
        off_q   <= addr[1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    timeoutCnt_d = timeoutCnt_q;
    err_d        = 1'b0;
    loadData_d   = loadData_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (startOk) begin
            state_d      = ACCESS;
            timeoutCnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          state_d = DONE;
          if (!we_q) loadData_d = loadExt;
        end else if (timeoutCnt_q == TimeoutLast) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          timeoutCnt_d = timeoutCnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Store lanes come from the live inputs so they can be registered at the start edge.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = store_data;
    if (write_en) begin
      case (funct3)
        3'b000: begin
          be_d    = 4'b0001 << addr[1:0];
          wdata_d = {4{store_data[7:0]}};
        end
        3'b001: begin
          be_d    = addr[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{store_data[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = store_data;
        end
      endcase
    end
  end

  always_comb begin
    byteSel = mem_rdata[{off_q, 3'b000} +: 8];
    halfSel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  loadExt = {{24{byteSel[7]}}, byteSel};
      3'b001:  loadExt = {{16{halfSel[15]}}, halfSel};
      3'b100:  loadExt = {24'h0, byteSel};
      3'b101:  loadExt = {16'h0, halfSel};
      default: loadExt = mem_rdata;
    endcase
  end

  always_comb begin
    mem_req   = (state_q == ACCESS);
    busy      = (state_q == ACCESS);
    done      = (state_q == DONE);
    err       = err_q;
    mem_we    = we_q;
    mem_addr  = addr_q;
    mem_be    = be_q;
    mem_wdata = wdata_q;
    load_data = loadData_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected requests and
// responses; a negedge monitor pops and compares them as the DUT presents them.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        read_en = 1'b0, write_en = 1'b0, mem_ready = 1'b0;
  logic [31:0] addr = '0, store_data = '0, mem_rdata = '0;
  logic [2:0]  funct3 = '0;
  logic        mem_req, mem_we, busy, done, err;
  logic [31:0] mem_addr, mem_wdata, load_data;
  logic [3:0]  mem_be;

  load_store_unit #(.TIMEOUT_CYCLES(16), .TIMEOUT_W(5)) dut (
    .clk(clk), .reset(reset), .read_en(read_en), .write_en(write_en),
    .addr(addr), .funct3(funct3), .store_data(store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .load_data(load_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          len;
  } req_t;

  typedef struct {
    logic        isErr;
    logic [31:0] loadData;
    int          cycle;
  } resp_t;

  req_t  reqQ[$];
  resp_t respQ[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: request fields/stability/length and response kind/timing/data.
  req_t  curReq;
  resp_t curResp;
  bit    reqSeen = 1'b0;
  int    reqCycles = 0;
  always @(negedge clk) begin
    if (reset) begin
      reqSeen = 1'b0;
    end else begin
      if (mem_req) begin
        checkOutput("busy_during_req", busy, 1);
        if (!reqSeen) begin
          if (reqQ.size() == 0) begin
            checkOutput("unexpected_req", mem_req, 0);
          end else begin
            curReq = reqQ.pop_front();
            checkOutput("mem_we", mem_we, curReq.we);
            checkOutput("mem_addr", mem_addr, curReq.addr);
            checkOutput("mem_be", mem_be, curReq.be);
            checkOutput("mem_wdata", mem_wdata, curReq.wdata);
          end
          reqSeen   = 1'b1;
          reqCycles = 1;
        end else begin
          reqCycles++;
          checkOutput("req_stable",
                      (mem_we === curReq.we && mem_addr === curReq.addr &&
                       mem_be === curReq.be && mem_wdata === curReq.wdata), 1);
        end
      end else if (reqSeen) begin
        if (curReq.len > 0) checkOutput("req_len", reqCycles, curReq.len);
        reqSeen = 1'b0;
      end
      if (done || err) begin
        if (respQ.size() == 0) begin
          checkOutput("unexpected_resp", {30'h0, done, err}, 0);
        end else begin
          curResp = respQ.pop_front();
          checkOutput("resp_err", err, curResp.isErr);
          checkOutput("resp_done", done, !curResp.isErr);
          checkOutput("resp_cycle", cyc, curResp.cycle);
          checkOutput("load_data", load_data, curResp.loadData);
          if (done) checkOutput("busy_at_done", busy, 0);
        end
      end
    end
  end

  // kind: 0 = completes after `delay` not-ready cycles, 1 = rejected at start, 2 = timeout.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [2:0] f3, input logic [31:0] sd,
                               input logic [31:0] rdata, input int delay, input int kind,
                               input logic [3:0] expBe, input logic [31:0] expWdata,
                               input logic [31:0] expLoad);
    req_t  q;
    resp_t r;
    @(negedge clk);
    q.we       = wr;
    q.addr     = {a[31:2], 2'b00};
    q.be       = expBe;
    q.wdata    = expWdata;
    q.len      = (kind == 2) ? 16 : delay + 1;
    r.isErr    = (kind != 0);
    r.loadData = expLoad;
    r.cycle    = cyc + ((kind == 0) ? delay + 2 : (kind == 1) ? 1 : 17);
    if (kind != 1) reqQ.push_back(q);
    respQ.push_back(r);
    read_en    = rd;
    write_en   = wr;
    addr       = a;
    funct3     = f3;
    store_data = sd;
    @(negedge clk);
    read_en  = 1'b0;
    write_en = 1'b0;
    if (kind == 0) begin
      mem_rdata = rdata;
      repeat (delay) @(negedge clk);
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
    end else if (kind == 2) begin
      repeat (20) @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_be", mem_be, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_load_data", load_data, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    #2 reset = 1'b0;

    // rd wr addr f3 store_data rdata delay kind be wdata load_data
    applyStimulus(0, 1, 32'h1003, 3'b000, 32'h0000_00A5, 32'h0, 0, 0, 4'b1000, 32'hA5A5_A5A5, 32'h0);
    applyStimulus(1, 0, 32'h2002, 3'b000, 32'h0, 32'h80FF_7F01, 0, 0, 4'b1111, 32'h0, 32'hFFFF_FFFF);
    applyStimulus(1, 0, 32'h2002, 3'b100, 32'h0, 32'h80FF_7F01, 0, 0, 4'b1111, 32'h0, 32'h0000_00FF);
    applyStimulus(1, 0, 32'h2003, 3'b000, 32'h0, 32'h80FF_7F01, 1, 0, 4'b1111, 32'h0, 32'hFFFF_FF80);
    applyStimulus(1, 0, 32'h3002, 3'b001, 32'h0, 32'h8001_1234, 3, 0, 4'b1111, 32'h0, 32'hFFFF_8001);
    applyStimulus(1, 0, 32'h4001, 3'b010, 32'h0, 32'h0, 0, 1, 4'b0000, 32'h0, 32'hFFFF_8001);
    applyStimulus(0, 1, 32'h4003, 3'b001, 32'h1111_2222, 32'h0, 0, 1, 4'b0000, 32'h0, 32'hFFFF_8001);
    applyStimulus(1, 0, 32'h4000, 3'b011, 32'h0, 32'h0, 0, 1, 4'b0000, 32'h0, 32'hFFFF_8001);
    applyStimulus(1, 1, 32'h4000, 3'b010, 32'h0, 32'h0, 0, 1, 4'b0000, 32'h0, 32'hFFFF_8001);
    applyStimulus(0, 1, 32'h5000, 3'b010, 32'h1234_5678, 32'h0, 0, 2, 4'b1111, 32'h1234_5678, 32'hFFFF_8001);
    applyStimulus(0, 1, 32'h6002, 3'b001, 32'h0000_BEEF, 32'h0, 2, 0, 4'b1100, 32'hBEEF_BEEF, 32'hFFFF_8001);
    applyStimulus(1, 0, 32'h7000, 3'b101, 32'h0, 32'h0000_F00D, 0, 0, 4'b1111, 32'h0, 32'h0000_F00D);
    applyStimulus(1, 0, 32'h7004, 3'b010, 32'h0, 32'hDEAD_BEEF, 1, 0, 4'b1111, 32'h0, 32'hDEAD_BEEF);

    // Reset while a load is waiting on memory.
    @(negedge clk);
    reqQ.push_back('{we: 1'b0, addr: 32'h9000, be: 4'b1111, wdata: 32'h0, len: 0});
    read_en = 1'b1;
    addr    = 32'h9000;
    funct3  = 3'b010;
    @(negedge clk);
    read_en = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_mid_mem_req", mem_req, 0);
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_load_data", load_data, 0);
    @(negedge clk);
    #2 reset = 1'b0;

    applyStimulus(1, 0, 32'h8001, 3'b100, 32'h0, 32'h0000_AB00, 0, 0, 4'b1111, 32'h0, 32'h0000_00AB);

    repeat (3) @(negedge clk);
    checkOutput("req_queue_empty", reqQ.size(), 0);
    checkOutput("resp_queue_empty", respQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
